// File: rtl/clock_divider_bank.sv
// Clock-and-reset generator: a shared lock-qualified release sequencer feeding NUM_CH
// programmable clock dividers, each with a one-cycle enable strobe and a staggered reset.
module clock_divider_bank #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RST_CYCLES = 32,
  parameter int unsigned STAGGER    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       reset_out
);

  localparam int unsigned T_MAX = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int unsigned SEQ_W = $clog2(T_MAX + 1);

  logic [SEQ_W-1:0] seq_q, seq_d;

  // Any cycle without lock restarts the whole release sequence; saturates at T_MAX.
  always_comb begin
    seq_d = seq_q;
    if (!locked) begin
      seq_d = '0;
    end else if (seq_q != SEQ_W'(T_MAX)) begin
      seq_d = seq_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned T_REL = RST_CYCLES + i * STAGGER;

    logic             rst_q;
    logic             rst_d;
    logic             held;
    logic [DIV_W-1:0] ph_q;
    logic [DIV_W-1:0] shadow_q;
    logic             div_q;
    logic             en_q;
    logic [DIV_W:0]   period;
    logic [DIV_W:0]   high_len;
    logic             wrap;

    assign rst_d = reset || (seq_d < SEQ_W'(T_REL));
    // Outputs stay quiet through the edge that drops reset_out, so the first period
    // starts cleanly on the following cycle; a new reset request clears them immediately.
    assign held  = rst_q || rst_d;

    always_comb begin
      period = {1'b0, shadow_q};
      if (shadow_q < DIV_W'(2)) begin
        period = (DIV_W + 1)'(2);
      end
      high_len = (period + (DIV_W + 1)'(1)) >> 1;
      wrap     = ({1'b0, ph_q} == period - (DIV_W + 1)'(1));
    end

    always_ff @(posedge clk) begin
      rst_q <= rst_d;
      if (held) begin
        ph_q     <= '0;
        shadow_q <= div[i*DIV_W +: DIV_W];
        div_q    <= 1'b0;
        en_q     <= 1'b0;
      end else begin
        div_q <= ({1'b0, ph_q} < high_len);
        en_q  <= (ph_q == '0);
        if (wrap) begin
          ph_q     <= '0;
          shadow_q <= div[i*DIV_W +: DIV_W];
        end else begin
          ph_q <= ph_q + DIV_W'(1);
        end
      end
    end

    assign reset_out[i] = rst_q;
    assign clk_div[i]   = div_q;
    assign clk_en[i]    = en_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: default 2-channel instance plus a
// 4-channel, zero-stagger, single-cycle-release instance.
module tb_clock_divider_bank;

  logic        clk = 1'b0;
  logic        reset, locked;
  logic [15:0] div;
  logic [1:0]  clk_div, clk_en, reset_out;

  logic        reset4, locked4;
  logic [31:0] div4;
  logic [3:0]  clk_div4, clk_en4, reset_out4;

  int edge_n;
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  clock_divider_bank u_dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .div       (div),
    .clk_div   (clk_div),
    .clk_en    (clk_en),
    .reset_out (reset_out)
  );

  clock_divider_bank #(
    .NUM_CH     (4),
    .DIV_W      (8),
    .RST_CYCLES (1),
    .STAGGER    (0)
  ) u_dut4 (
    .clk       (clk),
    .reset     (reset4),
    .locked    (locked4),
    .div       (div4),
    .clk_div   (clk_div4),
    .clk_en    (clk_en4),
    .reset_out (reset_out4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b1;
    div    = {8'd2, 8'd4};
    reset4 = 1'b1;
    locked4 = 1'b1;
    div4   = {4{8'd3}};
    tick();
    edge_n = 0;
    vectors++;
    if ({reset_out, clk_div, clk_en} !== 6'b11_00_00) begin
      miscompares++;
      $display("FAIL reset_state: got rst=%b div=%b en=%b, expected rst=11 div=00 en=00",
               reset_out, clk_div, clk_en);
    end
    vectors++;
    if ({reset_out4, clk_div4, clk_en4} !== 12'hF00) begin
      miscompares++;
      $display("FAIL reset_state4: got rst=%b div=%b en=%b, expected rst=1111 div=0 en=0",
               reset_out4, clk_div4, clk_en4);
    end
    reset = 1'b0;
  endtask

  // div={2,4}: ch0 released at 32, ch1 at 36; ch0 period 4, ch1 period 2.
  task automatic test_release();
    logic [1:0] exp_rst;
    logic [1:0] exp0, exp1;
    for (int e = 1; e <= 48; e++) begin
      tick();
      exp_rst = {1'(e < 36), 1'(e < 32)};
      vectors++;
      if (reset_out !== exp_rst) begin
        miscompares++;
        $display("FAIL release_rst edge %0d: got %b expected %b", e, reset_out, exp_rst);
      end
      exp0 = 2'b00;
      if (e >= 33) exp0 = {1'((e - 33) % 4 == 0), 1'((e - 33) % 4 < 2)};
      exp1 = 2'b00;
      if (e >= 37) exp1 = {1'((e - 37) % 2 == 0), 1'((e - 37) % 2 < 1)};
      vectors++;
      if ({clk_en[0], clk_div[0], clk_en[1], clk_div[1]} !== {exp0, exp1}) begin
        miscompares++;
        $display("FAIL release_out edge %0d: got en0/div0/en1/div1=%b expected %b", e,
                 {clk_en[0], clk_div[0], clk_en[1], clk_div[1]}, {exp0, exp1});
      end
    end
  endtask

  // Saturated sequencer keeps resets low; a one-cycle lock drop after edge 100 restarts it.
  task automatic test_lock_loss();
    while (edge_n < 100) begin
      tick();
      vectors++;
      if (reset_out !== 2'b00) begin
        miscompares++;
        $display("FAIL saturate edge %0d: got rst=%b expected 00", edge_n, reset_out);
      end
    end
    locked = 1'b0;
    tick();
    vectors++;
    if ({reset_out, clk_div, clk_en} !== 6'b11_00_00) begin
      miscompares++;
      $display("FAIL lock_loss edge %0d: got rst=%b div=%b en=%b expected 11/00/00",
               edge_n, reset_out, clk_div, clk_en);
    end
    locked   = 1'b1;
    div[7:0] = 8'd5;
    while (edge_n < 133) begin
      tick();
      if (edge_n >= 132) begin
        vectors++;
        if (reset_out[0] !== 1'(edge_n < 133)) begin
          miscompares++;
          $display("FAIL relock edge %0d: got rst0=%b expected %b", edge_n, reset_out[0],
                   1'(edge_n < 133));
        end
      end
    end
  endtask

  task automatic test_odd_ratio();
    logic [1:0] exp0;
    for (int e = 134; e <= 148; e++) begin
      tick();
      exp0 = {1'((e - 134) % 5 == 0), 1'((e - 134) % 5 < 3)};
      vectors++;
      if ({clk_en[0], clk_div[0]} !== exp0) begin
        miscompares++;
        $display("FAIL odd_ratio edge %0d: got en/div=%b expected %b", e,
                 {clk_en[0], clk_div[0]}, exp0);
      end
    end
  endtask

  // One-cycle reset mid-run, then the same release timing; ratio d0 (0 or 1) acts as 2.
  task automatic test_sync_reset(input logic [7:0] d0);
    logic [1:0] exp_rst;
    logic [1:0] exp0;
    div[7:0] = d0;
    reset    = 1'b1;
    tick();
    vectors++;
    if ({reset_out, clk_div, clk_en} !== 6'b11_00_00) begin
      miscompares++;
      $display("FAIL sync_reset d0=%0d: got rst=%b div=%b en=%b expected 11/00/00",
               d0, reset_out, clk_div, clk_en);
    end
    reset = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      tick();
      exp_rst = {1'(k < 36), 1'(k < 32)};
      exp0    = 2'b00;
      if (k >= 33) exp0 = {1'((k - 33) % 2 == 0), 1'((k - 33) % 2 == 0)};
      vectors++;
      if ({reset_out, clk_en[0], clk_div[0]} !== {exp_rst, exp0}) begin
        miscompares++;
        $display("FAIL sync_rerun d0=%0d k=%0d: got rst/en0/div0=%b expected %b", d0, k,
                 {reset_out, clk_en[0], clk_div[0]}, {exp_rst, exp0});
      end
    end
  endtask

  // Ratio 6 -> 3 written at output phase 2: current period stays 6, then 3-cycle periods.
  task automatic test_ratio_change();
    logic [1:0] exp0;
    div[7:0] = 8'd6;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k >= 33) begin
        if (k <= 38) exp0 = {1'(k == 33), 1'(k - 33 < 3)};
        else exp0 = {1'((k - 39) % 3 == 0), 1'((k - 39) % 3 < 2)};
        vectors++;
        if ({clk_en[0], clk_div[0]} !== exp0) begin
          miscompares++;
          $display("FAIL ratio_change k=%0d: got en/div=%b expected %b", k,
                   {clk_en[0], clk_div[0]}, exp0);
        end
      end
      if (k == 35) div[7:0] = 8'd3;
    end
  endtask

  task automatic test_four_channel();
    logic [7:0] exp_tbl [5];
    exp_tbl[0] = 8'h00;  // edge 1: {en,div}, reset_out checked separately
    exp_tbl[1] = 8'hFF;
    exp_tbl[2] = 8'h0F;
    exp_tbl[3] = 8'h00;
    exp_tbl[4] = 8'hFF;
    reset4 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (reset_out4 !== 4'h0) begin
        miscompares++;
        $display("FAIL four_ch_rst k=%0d: got %b expected 0000", k, reset_out4);
      end
      vectors++;
      if ({clk_en4, clk_div4} !== exp_tbl[k-1]) begin
        miscompares++;
        $display("FAIL four_ch_out k=%0d: got en/div=%h expected %h", k,
                 {clk_en4, clk_div4}, exp_tbl[k-1]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_n      = 0;
    test_reset();
    test_release();
    test_lock_loss();
    test_odd_ratio();
    test_sync_reset(8'd0);
    test_sync_reset(8'd1);
    test_ratio_change();
    test_four_channel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
